// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM register-bank configuration sequencer.
package pwm_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_FIN
  } pwm_seq_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned PWM_REG_STRIDE = 4;

endpackage

// File: rtl/pwm_axil_cfg_seq.sv
// AXI4-Lite master that writes a snapshot of NUM_REGS words to the PWM slave
// register bank and optionally reads each one back to verify it.
module pwm_axil_cfg_seq
  import pwm_cfg_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter bit VERIFY             = 1'b1
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]            cfg_base,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  output logic [$clog2(NUM_REGS):0]                err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                               M_AXI_AWPROT,
  output logic                                     M_AXI_AWVALID,
  input  logic                                     M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [3:0]                               M_AXI_WSTRB,
  output logic                                     M_AXI_WVALID,
  input  logic                                     M_AXI_WREADY,
  input  logic [1:0]                               M_AXI_BRESP,
  input  logic                                     M_AXI_BVALID,
  output logic                                     M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                               M_AXI_ARPROT,
  output logic                                     M_AXI_ARVALID,
  input  logic                                     M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                               M_AXI_RRESP,
  input  logic                                     M_AXI_RVALID,
  output logic                                     M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_REGS) + 1;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  pwm_seq_state_t    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [AW-1:0]     base_q, base_d;
  logic [DW-1:0]     snap_q [NUM_REGS];
  logic [DW-1:0]     snap_d [NUM_REGS];
  logic              err_q, err_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [AW-1:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  // Byte address of register i; wraps modulo 2^AW.
  function automatic logic [AW-1:0] reg_addr(input logic [AW-1:0] base,
                                             input logic [IDX_W-1:0] i);
    return base + AW'(i) * AW'(PWM_REG_STRIDE);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    snap_d    = snap_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    idx_nxt   = idx_q + IDX_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = cfg_base;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            snap_d[i] = cfg_data[i*DW +: DW];
          end
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          awaddr_d  = cfg_base;
          wdata_d   = cfg_data[DW-1:0];
          wstrb_d   = '1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once both have handshaken.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_FIN;
          end else if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (VERIFY) begin
              araddr_d  = base_q;
              arvalid_d = 1'b1;
              state_d   = S_RD_REQ;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            idx_d     = idx_nxt;
            awaddr_d  = reg_addr(base_q, idx_nxt);
            wdata_d   = snap_q[SEL_W'(idx_nxt)];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != AXI_RESP_OKAY || M_AXI_RDATA != snap_q[SEL_W'(idx_q)]) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_FIN;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d     = idx_nxt;
            araddr_d  = reg_addr(base_q, idx_nxt);
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      snap_q    <= snap_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy          = state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA};
  assign done          = (state_q == S_FIN);
  assign err           = err_q;
  assign err_idx       = err_idx_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_pwm_axil_cfg_seq.sv
// Randomised bench for pwm_axil_cfg_seq: AXI4-Lite slave with per-transaction
// latencies and fault injection, checked against a transaction-level model.
module tb_pwm_axil_cfg_seq;
  import pwm_cfg_pkg::*;

  localparam int NR = 4;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [31:0]      cfg_base = '0;
  logic [NR*32-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic             busy, done, err;
  logic [2:0]       err_idx;
  logic [31:0]      M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]       M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]       M_AXI_WSTRB;
  logic             M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic             M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic             M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]       M_AXI_BRESP = '0, M_AXI_RRESP = '0;
  logic [31:0]      M_AXI_RDATA = '0;

  pwm_axil_cfg_seq #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NR), .VERIFY(1'b1)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_base(cfg_base), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave configuration, indexed by write / read number within a sequence.
  int aw_lat[8], w_lat[8], b_del[8], ar_lat[8], r_del[8];
  int bad_b = -1, bad_r = -1, bad_r_kind = 0;
  logic [1:0] bad_resp = AXI_RESP_SLVERR;

  // Slave state and observation logs.
  int  wr_cnt, rd_cnt, aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, aw_hi0, w_hi0;
  bit  aw_got, w_got, b_pend, r_pend;
  logic [31:0] got_awaddr, got_wdata, rd_addr;
  logic        s_awv, s_wv, s_arv, s_bready, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        s_awv = 0; s_wv = 0; s_arv = 0; s_bready = 0; s_rready = 0;
      end else begin
        // Handshakes completed at the preceding rising edge.
        if (s_awv && M_AXI_AWREADY) begin aw_log.push_back(s_awaddr); got_awaddr = s_awaddr; aw_got = 1; aw_cnt = 0; end
        if (s_wv && M_AXI_WREADY)   begin w_log.push_back(s_wdata); got_wdata = s_wdata; w_got = 1; w_cnt = 0; end
        if (M_AXI_BVALID && s_bready) begin M_AXI_BVALID = 0; wr_cnt++; end
        if (s_arv && M_AXI_ARREADY) begin ar_log.push_back(s_araddr); rd_addr = s_araddr; r_pend = 1; r_wait = 0; ar_cnt = 0; end
        if (M_AXI_RVALID && s_rready) begin M_AXI_RVALID = 0; rd_cnt++; end
        if (aw_got && w_got) begin
          mem[got_awaddr] = got_wdata;
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
        if (b_pend) begin
          if (b_wait >= b_del[wr_cnt]) begin
            M_AXI_BVALID = 1;
            M_AXI_BRESP  = (wr_cnt == bad_b) ? bad_resp : AXI_RESP_OKAY;
            b_pend = 0;
          end else b_wait++;
        end
        if (r_pend) begin
          if (r_wait >= r_del[rd_cnt]) begin
            M_AXI_RVALID = 1;
            M_AXI_RDATA  = (rd_cnt == bad_r && bad_r_kind == 0) ? 32'h0000_DEAD :
                           (mem.exists(rd_addr) ? mem[rd_addr] : 32'h0);
            M_AXI_RRESP  = (rd_cnt == bad_r && bad_r_kind == 1) ? bad_resp : AXI_RESP_OKAY;
            r_pend = 0;
          end else r_wait++;
        end
        if (M_AXI_AWVALID && wr_cnt == 0) aw_hi0++;
        if (M_AXI_WVALID && wr_cnt == 0)  w_hi0++;
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt + 1 >= aw_lat[wr_cnt]);
        M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt + 1 >= w_lat[wr_cnt]);
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt + 1 >= ar_lat[rd_cnt]);
        if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
        if (M_AXI_WVALID && !M_AXI_WREADY)   w_cnt++;
        if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_cnt++;
        s_awv = M_AXI_AWVALID; s_awaddr = M_AXI_AWADDR;
        s_wv  = M_AXI_WVALID;  s_wdata  = M_AXI_WDATA;
        s_arv = M_AXI_ARVALID; s_araddr = M_AXI_ARADDR;
        s_bready = M_AXI_BREADY; s_rready = M_AXI_RREADY;
      end
    end
  end

  // Model-side expectations shared with the compare process.
  int start_cyc = -100, done_cyc = -100, obs_done_cyc = -1;
  bit chk_en = 0, seen_done = 0;

  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  initial begin
    p_awv = 0; p_wv = 0; p_arv = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETN || !chk_en) begin
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        chk("busy", busy, (cyc > start_cyc) && (cyc < done_cyc));
        chk("done", done, cyc == done_cyc);
        if (done) begin seen_done = 1; obs_done_cyc = cyc; end
        if (p_awv) begin
          if (p_awr) chk("aw_drop", M_AXI_AWVALID, 1'b0);
          else       chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
        end
        if (p_wv) begin
          if (p_wr) chk("w_drop", M_AXI_WVALID, 1'b0);
          else      chk("w_hold", {M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {1'b1, p_wstrb, p_wdata});
        end
        if (p_arv) begin
          if (p_arr) chk("ar_drop", M_AXI_ARVALID, 1'b0);
          else       chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
        end
        p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      end
    end
  end

  task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
    for (int i = 0; i < 8; i++) begin
      aw_lat[i] = a; w_lat[i] = w; b_del[i] = b; ar_lat[i] = ar; r_del[i] = r;
    end
    bad_b = -1; bad_r = -1; bad_r_kind = 0; bad_resp = AXI_RESP_SLVERR;
  endtask

  task automatic run_seq(input logic [31:0] base, input logic [NR*32-1:0] data, input bit noise);
    int t, n_wr, n_rd;
    bit e_err;
    int e_idx;
    logic [31:0] ea;
    aw_log.delete(); w_log.delete(); ar_log.delete(); mem.delete();
    wr_cnt = 0; rd_cnt = 0; aw_hi0 = 0; w_hi0 = 0;
    seen_done = 0; obs_done_cyc = -1;
    // Transaction-level model: cycle cost of each transfer and where it stops.
    t = 1; e_err = 0; e_idx = 0; n_wr = NR; n_rd = 0;
    for (int i = 0; i < NR; i++) begin
      t += ((aw_lat[i] > w_lat[i]) ? aw_lat[i] : w_lat[i]) + 1 + b_del[i];
      if (i == bad_b) begin e_err = 1; e_idx = i; n_wr = i + 1; break; end
    end
    if (!e_err) begin
      n_rd = NR;
      for (int i = 0; i < NR; i++) begin
        t += ar_lat[i] + 1 + r_del[i];
        if (i == bad_r) begin e_err = 1; e_idx = i; n_rd = i + 1; break; end
      end
    end
    cfg_base = base; cfg_data = data; start = 1;
    start_cyc = cyc; done_cyc = cyc + t; chk_en = 1;
    for (int k = 0; k < t + 40; k++) begin
      @(negedge ACLK);
      if (cyc > done_cyc + 1) break;
      if (noise && cyc <= done_cyc) begin
        start    = (cyc == done_cyc) ? 1'b1 : 1'($urandom_range(0, 1));
        cfg_base = $urandom;
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
      end else start = 0;
    end
    start = 0;
    chk("done_seen", seen_done, 1'b1);
    chk("err", err, e_err);
    chk("err_idx", err_idx, 3'(e_idx));
    chk("n_aw", aw_log.size(), n_wr);
    chk("n_w", w_log.size(), n_wr);
    chk("n_ar", ar_log.size(), n_rd);
    for (int i = 0; i < n_wr; i++) begin
      ea = base + 32'(4 * i);
      if (i < aw_log.size()) chk("aw_addr", aw_log[i], ea);
      if (i < w_log.size())  chk("w_data", w_log[i], data[32*i +: 32]);
    end
    for (int i = 0; i < n_rd; i++) begin
      ea = base + 32'(4 * i);
      if (i < ar_log.size()) chk("ar_addr", ar_log[i], ea);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {busy, done, err, err_idx, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WSTRB,
                         M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, '0);
    chk({tag, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, '0);
    chk({tag, "_wdata"}, M_AXI_WDATA, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*32-1:0] d;
    int kind;
    set_lat(1, 1, 0, 1, 0);
    repeat (3) @(negedge ACLK);
    chk_reset_outputs("reset");
    ARESETN = 1;
    repeat (2) @(negedge ACLK);

    // Zero-wait slave, base 0, data 1..4.
    d = {32'd4, 32'd3, 32'd2, 32'd1};
    run_seq(32'h0, d, 0);
    chk("t1_latency", obs_done_cyc - start_cyc, 17);
    if (aw_log.size() == 4) chk("t1_aw3", aw_log[3], 32'hC);
    if (w_log.size() == 4)  chk("t1_w2", w_log[2], 32'd3);
    chk("t1_err", err, 1'b0);

    // AWREADY held off for 3 cycles on the first write; WREADY immediate.
    set_lat(1, 1, 0, 1, 0);
    aw_lat[0] = 3;
    run_seq(32'h4000_0000, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("t2_aw_hi", aw_hi0, 3);
    chk("t2_w_hi", w_hi0, 1);

    // SLVERR on the third write: no reads.
    set_lat(1, 1, 0, 1, 0);
    bad_b = 2;
    run_seq(32'h10, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("t3_err_idx", err_idx, 3'd2);
    chk("t3_no_ar", ar_log.size(), 0);

    // Corrupt readback of register 1.
    set_lat(1, 1, 0, 1, 0);
    bad_r = 1; bad_r_kind = 0;
    run_seq(32'h20, {$urandom, $urandom, $urandom, 32'h1234_5678}, 0);
    chk("t4_err_idx", err_idx, 3'd1);
    chk("t4_n_ar", ar_log.size(), 2);

    // Start and configuration noise while busy and in the done cycle.
    set_lat(1, 1, 0, 1, 0);
    run_seq(32'h80, {$urandom, $urandom, $urandom, $urandom}, 1);

    // Address wrap at the top of the address space.
    set_lat(1, 2, 1, 1, 0);
    run_seq(32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 0);
    if (aw_log.size() == 4) chk("t6_wrap", aw_log[2], 32'h0);

    // Reset while WVALID is pending.
    set_lat(1, 6, 0, 1, 0);
    chk_en = 0;
    cfg_base = 32'h100; cfg_data = {$urandom, $urandom, $urandom, $urandom}; start = 1;
    @(negedge ACLK);
    start = 0;
    for (int k = 0; k < 20 && !M_AXI_WVALID; k++) @(negedge ACLK);
    chk("t7_wvalid", M_AXI_WVALID, 1'b1);
    #2 ARESETN = 0;
    #1 chk_reset_outputs("t7_async");
    start_cyc = -100; done_cyc = -100;
    repeat (3) @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    set_lat(1, 1, 0, 1, 0);
    run_seq(32'h200, {$urandom, $urandom, $urandom, $urandom}, 0);

    // Random latencies, faults and noise.
    for (int s = 0; s < 10; s++) begin
      set_lat(1, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
        aw_lat[i] = $urandom_range(1, 4); w_lat[i] = $urandom_range(1, 4);
        b_del[i]  = $urandom_range(0, 2); ar_lat[i] = $urandom_range(1, 4);
        r_del[i]  = $urandom_range(0, 2);
      end
      kind = $urandom_range(0, 3);
      bad_resp = 2'($urandom_range(1, 3));
      if (kind == 1) bad_b = $urandom_range(0, NR - 1);
      if (kind >= 2) begin bad_r = $urandom_range(0, NR - 1); bad_r_kind = kind - 2; end
      run_seq($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge ACLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
